clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Multi-channel, runtime-programmable clock divider that generalises the fixed single-divisor divider. It turns one system clock into CH independent divided outputs (near-50% square wave plus a one-cycle tick strobe per channel). Each channel has its own enable and a divisor that can be rewritten while running; new divisors take effect glitch-free at the next period boundary. It feeds the UART baud generators and the other slow-peripheral clock enables.

## Interface
- CH, 4, number of channels (>=2)
- DIV_W, 16, divisor/counter width
- DEFAULT_DIV, 2, divisor loaded into every channel at reset (2 .. 2^DIV_W-1)
- clk_in  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- ch_en  in  CH  per-channel run enable, level
- sync  in  1  one-cycle pulse; phase-aligns all channels
- wr_en  in  1  divisor write strobe
- wr_ch  in  $clog2(CH)  channel index for write
- wr_div  in  DIV_W  new divisor value
- clk_out  out  CH  divided clock, registered
- tick  out  CH  one-cycle strobe on last cycle of each period, registered
- pend  out  CH  divisor write waiting for period boundary

## Operation
- Per channel i: cnt_i (DIV_W), div_i (active), pdiv_i (pending), pend_i, en_r_i (registered ch_en[i]).
- Effective divisor D = max(div_i, 1); values 0 and 1 both behave as D=1.
- Disabled (en_r_i=0): cnt_i held 0; clk_out[i]=0, tick[i]=0.
- Enabled: cnt_i counts 0..D-1 and wraps to 0; unsigned, no overflow since cnt < D <= 2^DIV_W-1.
- clk_out[i] = en_r_i & (cnt_i < D - floor(D/2)): high ceil(D/2) cycles, low floor(D/2) cycles. D=1: clk_out held 1.
- tick[i] = en_r_i & (cnt_i == D-1). D=1: tick high every cycle.
- Outputs registered but aligned to cnt_i (flop next-state lookahead); no combinational path from inputs to outputs.
- Divisor write (wr_en=1, wr_ch=i):
  - wr_ch >= CH: ignored.
  - Channel disabled, or the write cycle is the wrap cycle (cnt_i==D-1), or sync=1: div_i <= wr_div at that edge, pend_i stays/clears 0.
  - Otherwise: pdiv_i <= wr_div, pend_i <= 1; a later write before application overwrites pdiv_i.
- Pending application: at the wrap edge (cnt_i D-1 -> 0), div_i <= pdiv_i, pend_i <= 0. The new period starts with the new divisor at cnt 0.
- sync=1: at that edge every enabled channel sets cnt_i <= 0 and applies any pending divisor. sync takes priority over counting and wrap. Disabled channels are unaffected.
- Disable (en_r_i 1->0): cnt_i <= 0, pending divisor applied, pend_i <= 0. Outputs are 0 after that edge.
- Enable (en_r_i 0->1): counting starts from cnt 0 with current div_i.

## Timing
- Reset (async assert): cnt=0, div=DEFAULT_DIV, pdiv=0, pend=0, en_r=0, clk_out=0, tick=0 for all channels. Release is synchronous to clk_in.
- Enable latency: ch_en[i] sampled high at edge k. After edge k, clk_out[i]=1 and cnt_i=0. After edge k+D-1, tick[i]=1.
- Period is exactly D clk_in cycles. tick[i] is high 1 cycle per period, coinciding with the last low cycle of clk_out[i] (D>=2).
- Write latency: disabled channel, 1 edge. Running channel, applied at the next wrap edge, so the current period always completes with the old divisor.
- sync latency: after the sync edge, all enabled channels show cnt 0 (clk_out=1) on the same cycle.
- Simultaneous sync + ch_en rise: channel starts at cnt 0, consistent with the enable rule.

## Test plan
- Reset then enable ch0 with default D=2 → clk_out[0] toggles every cycle, tick[0] high every 2nd cycle, first clk_out high 1 cycle after enable edge.
- Write D=5 to ch1 while disabled, enable → clk_out[1] high 3 cycles / low 2 cycles, tick on 5th cycle, pend[1] never asserts.
- ch2 running at D=4, write D=7 at cnt=1 → pend[2]=1 until wrap, 4-cycle period completes, then 7-cycle periods (4 high/3 low); second write of D=3 before wrap → only 3 takes effect.
- ch0 D=3 and ch3 D=6 running out of phase, pulse sync → both at cnt 0 next cycle, both clk_out high, ticks coincide every 6 cycles.
- Write D=0 and D=1 to ch1 → tick[1] continuous high, clk_out[1] held 1. Write with wr_ch>=CH (CH=3 build) → no state change.
- Assert rst mid-period with pend set → all outputs 0 immediately, div back to DEFAULT_DIV, pend cleared.

Source files
------------

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider: CH independent square-wave outputs
// with per-period tick strobes and glitch-free divisor updates at period boundaries.

module clk_div_ch #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             ch_en,
    input  logic             sync,
    input  logic             wr_hit,
    input  logic [DIV_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);
    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt, div, pdiv;
    logic             en_r;
    logic [DIV_W-1:0] cnt_n, div_n, pdiv_n, d, d_n;
    logic             pend_n, wrap, apply;

    // Divisors 0 and 1 both run as divide-by-one.
    function automatic logic [DIV_W-1:0] eff(input logic [DIV_W-1:0] v);
        return (v[DIV_W-1:1] == '0) ? ONE : v;
    endfunction

    always_comb begin
        d      = eff(div);
        wrap   = en_r && (cnt == d - ONE);
        // Period boundaries where a pending divisor may land: wrap, sync, disable.
        apply  = en_r && (!ch_en || sync || wrap);
        cnt_n  = (en_r && ch_en && !sync && !wrap) ? cnt + ONE : '0;
        div_n  = div;
        pdiv_n = pdiv;
        pend_n = pend;
        if (wr_hit && (!en_r || apply)) begin
            div_n  = wr_div;
            pend_n = 1'b0;
        end else if (wr_hit) begin
            pdiv_n = wr_div;
            pend_n = 1'b1;
        end else if (apply && pend) begin
            div_n  = pdiv;
            pend_n = 1'b0;
        end
        d_n = eff(div_n);
    end

    // Outputs are computed from next-state so they line up with cnt.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            div     <= DIV_W'(DEFAULT_DIV);
            pdiv    <= '0;
            pend    <= 1'b0;
            en_r    <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_n;
            div     <= div_n;
            pdiv    <= pdiv_n;
            pend    <= pend_n;
            en_r    <= ch_en;
            clk_out <= ch_en && (cnt_n < d_n - (d_n >> 1));
            tick    <= ch_en && (cnt_n == d_n - ONE);
        end
    end
endmodule

module clk_div_bank #(
    parameter int CH          = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [CH-1:0]         ch_en,
    input  logic                  sync,
    input  logic                  wr_en,
    input  logic [$clog2(CH)-1:0] wr_ch,
    input  logic [DIV_W-1:0]      wr_div,
    output logic [CH-1:0]         clk_out,
    output logic [CH-1:0]         tick,
    output logic [CH-1:0]         pend
);
    logic [CH-1:0] wr_hit;

    // Out-of-range wr_ch never matches any lane index, so it is dropped.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign wr_hit[i] = wr_en && (32'(wr_ch) == i);

        clk_div_ch #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk_in (clk_in),
            .rst    (rst),
            .ch_en  (ch_en[i]),
            .sync   (sync),
            .wr_hit (wr_hit[i]),
            .wr_div (wr_div),
            .clk_out(clk_out[i]),
            .tick   (tick[i]),
            .pend   (pend[i])
        );
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a vector table for enable/default-divisor
// behaviour plus hand sequences for pending writes, sync, D<=1, bad index and reset.

module tb_clk_div_bank;
    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  ch_en = '0;
    logic        sync = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [15:0] wr_div = '0;
    logic [3:0]  clk_out, tick, pend;
    logic [2:0]  ch_en3 = '0;
    logic [2:0]  clk_out3, tick3, pend3;

    int total = 0;
    int bad = 0;

    always #5 clk_in = ~clk_in;

    clk_div_bank #(.CH(4), .DIV_W(16), .DEFAULT_DIV(2)) u4 (
        .clk_in(clk_in), .rst(rst), .ch_en(ch_en), .sync(sync), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_div(wr_div), .clk_out(clk_out), .tick(tick), .pend(pend)
    );

    clk_div_bank #(.CH(3), .DIV_W(16), .DEFAULT_DIV(2)) u3 (
        .clk_in(clk_in), .rst(rst), .ch_en(ch_en3), .sync(sync), .wr_en(wr_en),
        .wr_ch(wr_ch), .wr_div(wr_div), .clk_out(clk_out3), .tick(tick3), .pend(pend3)
    );

    typedef struct {
        logic [3:0]  en;
        logic        wr;
        logic [1:0]  ch;
        logic [15:0] dv;
        logic [3:0]  ec;
        logic [3:0]  et;
        logic [3:0]  ep;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input int ch, input int v);
        wr_en  = 1'b1;
        wr_ch  = ch[1:0];
        wr_div = v[15:0];
    endtask

    task automatic wr_cyc(input int ch, input int v);
        wr(ch, v);
        cyc();
        wr_en = 1'b0;
    endtask

    // Expected outputs of a running channel at counter value c with divisor d.
    task automatic expect_ch(input string nm, input int ch, input int d, input int c);
        chk({nm, ".clk"}, 32'(clk_out[ch]), 32'(c < d - d / 2));
        chk({nm, ".tick"}, 32'(tick[ch]), 32'(c == d - 1));
    endtask

    initial begin
        // ch0 default D=2, ch1 written D=5 while disabled then enabled
        vecs[0] = '{4'b0001, 1'b1, 2'd1, 16'd5, 4'b0001, 4'b0000, 4'b0000};
        vecs[1] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0001, 4'b0000};
        vecs[2] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0011, 4'b0000, 4'b0000};
        vecs[3] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0001, 4'b0000};
        vecs[4] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0001, 4'b0000, 4'b0000};
        vecs[5] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0011, 4'b0000};
        vecs[6] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0011, 4'b0000, 4'b0000};
        vecs[7] = '{4'b0011, 1'b0, 2'd0, 16'd0, 4'b0010, 4'b0001, 4'b0000};
        vecs[8] = '{4'b0000, 1'b0, 2'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};

        #12;
        chk("rst.clk", 32'(clk_out), 0);
        chk("rst.tick", 32'(tick), 0);
        chk("rst.pend", 32'(pend), 0);
        @(negedge clk_in);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            ch_en  = vecs[i].en;
            wr_en  = vecs[i].wr;
            wr_ch  = vecs[i].ch;
            wr_div = vecs[i].dv;
            cyc();
            chk($sformatf("vec%0d.clk", i), 32'(clk_out), 32'(vecs[i].ec));
            chk($sformatf("vec%0d.tick", i), 32'(tick), 32'(vecs[i].et));
            chk($sformatf("vec%0d.pend", i), 32'(pend), 32'(vecs[i].ep));
        end
        wr_en = 1'b0;

        // ch2 D=4, write 7 mid-period: old period completes, then D=7
        wr_cyc(2, 4);
        chk("pw.pend_dis", 32'(pend[2]), 0);
        ch_en = 4'b0100;
        cyc(); expect_ch("pw.c0", 2, 4, 0);
        cyc(); expect_ch("pw.c1", 2, 4, 1);
        wr_cyc(2, 7);
        chk("pw.pend1", 32'(pend[2]), 1);
        expect_ch("pw.c2", 2, 4, 2);
        cyc(); expect_ch("pw.c3", 2, 4, 3);
        chk("pw.pend2", 32'(pend[2]), 1);
        cyc();
        chk("pw.pend_clr", 32'(pend[2]), 0);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) cyc();
            expect_ch($sformatf("pw.d7_%0d", k), 2, 7, k % 7);
        end
        // two writes before the wrap: only the last lands
        cyc(); cyc();
        wr(2, 5); cyc();
        wr(2, 3); cyc();
        wr_en = 1'b0;
        cyc(); cyc(); cyc();
        chk("pw.pend3", 32'(pend[2]), 1);
        expect_ch("pw.c6", 2, 7, 6);
        cyc();
        chk("pw.pend_clr2", 32'(pend[2]), 0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            expect_ch($sformatf("pw.d3_%0d", k), 2, 3, k % 3);
        end
        ch_en = 4'b0000;
        cyc();
        chk("dis.clk", 32'(clk_out), 0);

        // sync realigns ch0 D=3 and ch3 D=6
        wr_cyc(0, 3);
        wr_cyc(3, 6);
        ch_en = 4'b0001; cyc();
        ch_en = 4'b1001; cyc();
        cyc();
        expect_ch("sy.pre0", 0, 3, 2);
        expect_ch("sy.pre3", 3, 6, 1);
        sync = 1'b1; cyc(); sync = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) cyc();
            expect_ch($sformatf("sy.a%0d", k), 0, 3, k % 3);
            expect_ch($sformatf("sy.b%0d", k), 3, 6, k % 6);
        end
        ch_en = 4'b0000;
        cyc();

        // D=0 then D=1: continuous tick, clk_out held high, no pending
        wr_cyc(1, 0);
        ch_en = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("d0.clk%0d", k), 32'(clk_out[1]), 1);
            chk($sformatf("d0.tick%0d", k), 32'(tick[1]), 1);
        end
        wr_cyc(1, 1);
        chk("d1.pend", 32'(pend[1]), 0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d1.clk%0d", k), 32'(clk_out[1]), 1);
            chk($sformatf("d1.tick%0d", k), 32'(tick[1]), 1);
            cyc();
        end

        // reset mid-period with a write pending
        ch_en = 4'b0100;
        cyc(); cyc();
        wr_cyc(2, 7);
        chk("rs.pend_set", 32'(pend[2]), 1);
        #2 rst = 1'b0;
        #1;
        chk("rs.clk", 32'(clk_out), 0);
        chk("rs.tick", 32'(tick), 0);
        chk("rs.pend", 32'(pend), 0);
        @(negedge clk_in);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            expect_ch($sformatf("rs.def%0d", k), 2, 2, k % 2);
        end

        // CH=3 build: a write to index 3 must not touch any channel
        ch_en  = 4'b0000;
        ch_en3 = 3'b111;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) wr(3, 1);
            else wr_en = 1'b0;
            cyc();
            chk($sformatf("oob.clk%0d", k), 32'(clk_out3), (k % 2 == 0) ? 7 : 0);
            chk($sformatf("oob.tick%0d", k), 32'(tick3), (k % 2 == 1) ? 7 : 0);
            chk($sformatf("oob.pend%0d", k), 32'(pend3), 0);
        end
        wr_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
